// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and default timing for the I2C request arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    GAP
  } arb_state_t;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_XFER_CYC  = 22;
  localparam int DEF_STOP_HOLD = 2;
  localparam int DEF_GAP_CYC   = 3;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and i2c_master-side signals of the arbiter.
interface i2c_req_arbiter_if #(
  parameter int NREQ = i2c_arb_pkg::DEF_NREQ
) ();
  import i2c_arb_pkg::*;

  logic [NREQ-1:0]                   req;
  logic [NREQ-1:0]                   req_rw;
  logic [NREQ-1:0][I2C_ADDR_W-1:0]   req_addr;
  logic [NREQ-1:0][I2C_DATA_W-1:0]   req_wdata;
  logic [NREQ-1:0]                   gnt;
  logic [NREQ-1:0]                   done;
  logic                              busy;
  logic                              m_start;
  logic                              m_stop;
  logic                              m_rw;
  logic [I2C_ADDR_W-1:0]             m_addr;
  logic [I2C_DATA_W-1:0]             m_wdata;

  // Arbiter side
  modport master (
    input  req, req_rw, req_addr, req_wdata,
    output gnt, done, busy, m_start, m_stop, m_rw, m_addr, m_wdata
  );

  // Client / i2c_master side
  modport slave (
    output req, req_rw, req_addr, req_wdata,
    input  gnt, done, busy, m_start, m_stop, m_rw, m_addr, m_wdata
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         onehot,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    valid
);
  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sequencing one full i2c_master transfer per grant,
// followed by a bus-free gap.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int XFER_CYC  = DEF_XFER_CYC,
  parameter int STOP_HOLD = DEF_STOP_HOLD,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input logic               clk,
  input logic               reset,
  i2c_req_arbiter_if.master bus
);
  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (XFER_CYC > GAP_CYC) ? XFER_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] STOP_TH   = CNT_W'(STOP_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  arb_state_t               state, state_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_n;
  logic [NREQ-1:0]          pick_oh;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_valid;
  logic [NREQ-1:0]          gnt_n, done_n;
  logic                     busy_n, m_start_n, m_stop_n, m_rw_n;
  logic [I2C_ADDR_W-1:0]    m_addr_n;
  logic [I2C_DATA_W-1:0]    m_wdata_n;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rr_ptr_n  = rr_ptr;
    gnt_n     = bus.gnt;
    done_n    = '0;
    m_start_n = 1'b0;
    m_stop_n  = bus.m_stop;
    m_rw_n    = bus.m_rw;
    m_addr_n  = bus.m_addr;
    m_wdata_n = bus.m_wdata;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n   = START;
          gnt_n     = pick_oh;
          m_start_n = 1'b1;
          m_rw_n    = bus.req_rw[pick_idx];
          m_addr_n  = bus.req_addr[pick_idx];
          m_wdata_n = bus.req_wdata[pick_idx];
          rr_ptr_n  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_ONE;
        end
      end
      START: begin
        state_n  = XFER;
        cnt_n    = XFER_LAST;
        // Covers STOP_HOLD == XFER_CYC, where stop spans the whole transfer
        m_stop_n = (XFER_LAST < STOP_TH);
      end
      XFER: begin
        if (cnt == '0) begin
          state_n  = GAP;
          cnt_n    = GAP_LAST;
          m_stop_n = 1'b0;
          gnt_n    = '0;
          done_n   = bus.gnt;
        end else begin
          cnt_n    = cnt - CNT_ONE;
          m_stop_n = (cnt_n < STOP_TH);
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_ONE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      bus.gnt     <= '0;
      bus.done    <= '0;
      bus.busy    <= 1'b0;
      bus.m_start <= 1'b0;
      bus.m_stop  <= 1'b0;
      bus.m_rw    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rr_ptr      <= rr_ptr_n;
      bus.gnt     <= gnt_n;
      bus.done    <= done_n;
      bus.busy    <= busy_n;
      bus.m_start <= m_start_n;
      bus.m_stop  <= m_stop_n;
      bus.m_rw    <= m_rw_n;
      bus.m_addr  <= m_addr_n;
      bus.m_wdata <= m_wdata_n;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: vector table plus hand-written corner sequences.
module tb_i2c_req_arbiter;
  localparam int NREQ  = 4;
  localparam int XFER  = 22;
  localparam int STOPH = 2;
  localparam int GAPC  = 3;
  localparam int TOTAL = 2 + XFER + GAPC;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_req_arbiter #(
    .NREQ      (NREQ),
    .XFER_CYC  (XFER),
    .STOP_HOLD (STOPH),
    .GAP_CYC   (GAPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  typedef struct {
    logic [NREQ-1:0] req;
    int              idx;
    logic            rw;
    logic [6:0]      addr;
    logic [7:0]      wdata;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({bus.gnt, bus.done, bus.busy, bus.m_start, bus.m_stop,
                     bus.m_rw, bus.m_addr, bus.m_wdata}), 64'(0));
  endtask

  task automatic set_inputs(input int idx, input logic rw, input logic [6:0] addr,
                            input logic [7:0] wdata);
    bus.req_rw[idx]    = rw;
    bus.req_addr[idx]  = addr;
    bus.req_wdata[idx] = wdata;
  endtask

  // Entered on the negedge where req was presented in IDLE; returns on the
  // negedge where the arbiter is back in IDLE.
  task automatic check_xfer(input int idx, input logic rw, input logic [6:0] addr,
                            input logic [7:0] wdata, input int drop_at, input int chg_at);
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_start, e_stop, e_busy;
    oh = NREQ'(1) << idx;
    for (int c = 1; c <= TOTAL; c++) begin
      @(negedge clk);
      e_gnt   = (c <= 1 + XFER) ? oh : '0;
      e_done  = (c == 2 + XFER) ? oh : '0;
      e_start = (c == 1);
      e_stop  = (c > 1 + XFER - STOPH) && (c <= 1 + XFER);
      e_busy  = (c <= 1 + XFER + GAPC);
      check($sformatf("ctrl[req%0d c%0d]", idx, c),
            64'({bus.gnt, bus.done, bus.m_start, bus.m_stop, bus.busy}),
            64'({e_gnt, e_done, e_start, e_stop, e_busy}));
      check($sformatf("data[req%0d c%0d]", idx, c),
            64'({bus.m_rw, bus.m_addr, bus.m_wdata}), 64'({rw, addr, wdata}));
      if (c == drop_at) bus.req[idx] = 1'b0;
      if (c == chg_at)  bus.req_addr[idx] = 7'h11;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // winner idx hand-derived from the round-robin pointer carried between rows
    tbl[0] = '{4'b0001, 0, 1'b0, 7'h50, 8'hA5};
    tbl[1] = '{4'b1001, 3, 1'b1, 7'h7F, 8'hFF};
    tbl[2] = '{4'b0110, 1, 1'b1, 7'h00, 8'h00};
    tbl[3] = '{4'b0011, 0, 1'b0, 7'h12, 8'h34};
    tbl[4] = '{4'b0011, 1, 1'b1, 7'h21, 8'h3C};
    tbl[5] = '{4'b0100, 2, 1'b0, 7'h6A, 8'h0F};
    tbl[6] = '{4'b0011, 0, 1'b0, 7'h50, 8'hA5};
    tbl[7] = '{4'b0011, 1, 1'b1, 7'h21, 8'h3C};
    tbl[8] = '{4'b1000, 3, 1'b1, 7'h7F, 8'hFF};

    reset         = 1'b1;
    bus.req       = '1;
    bus.req_rw    = '1;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    #2 reset = 1'b0;
    #1 check_zero("reset_async");
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_held");
    end
    bus.req = '0;
    reset   = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    for (int v = 0; v < 9; v++) begin
      bus.req = tbl[v].req;
      set_inputs(tbl[v].idx, tbl[v].rw, tbl[v].addr, tbl[v].wdata);
      check_xfer(tbl[v].idx, tbl[v].rw, tbl[v].addr, tbl[v].wdata, 0, 0);
      bus.req = '0;
    end

    // Request withdrawn mid-XFER: timing unchanged (ptr 0 -> grant 1)
    bus.req = 4'b0010;
    set_inputs(1, 1'b1, 7'h21, 8'h3C);
    check_xfer(1, 1'b1, 7'h21, 8'h3C, 10, 0);
    bus.req = '0;

    // Address input changed mid-XFER: m_addr holds until next grant
    bus.req = 4'b0001;
    set_inputs(0, 1'b0, 7'h50, 8'hA5);
    check_xfer(0, 1'b0, 7'h50, 8'hA5, 0, 12);
    check_xfer(0, 1'b0, 7'h11, 8'hA5, 0, 0);
    bus.req = '0;

    // Continuous contention from reset: 0,1,2,3,0 back to back
    set_inputs(0, 1'b0, 7'h50, 8'hA5);
    set_inputs(1, 1'b1, 7'h21, 8'h3C);
    set_inputs(2, 1'b0, 7'h6A, 8'h0F);
    set_inputs(3, 1'b1, 7'h7F, 8'hFF);
    bus.req = '1;
    reset   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_xfer(0, 1'b0, 7'h50, 8'hA5, 0, 0);
    check_xfer(1, 1'b1, 7'h21, 8'h3C, 0, 0);
    check_xfer(2, 1'b0, 7'h6A, 8'h0F, 0, 0);
    check_xfer(3, 1'b1, 7'h7F, 8'hFF, 0, 0);
    check_xfer(0, 1'b0, 7'h50, 8'hA5, 0, 0);

    // Mid-transfer reset at XFER cycle 10, then pointer must restart at 0
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1)
        check("abort_grant", 64'({bus.gnt, bus.m_start}), 64'({4'b0001, 1'b1}));
    end
    check("abort_pre", 64'({bus.gnt, bus.busy, bus.m_start}), 64'({4'b0001, 1'b1, 1'b0}));
    reset = 1'b0;
    #1 check_zero("abort_async");
    repeat (3) begin
      @(negedge clk);
      check_zero("abort_held");
    end
    reset = 1'b1;
    check_xfer(0, 1'b0, 7'h50, 8'hA5, 0, 0);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("final_idle", 64'({bus.gnt, bus.busy}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
